obstacle_scheduler: RTL and testbench
=====================================

OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 Param OBS_X_START, 8'd159, x position at which a new obstacle appears.
REQ-002 Param SPAWN_MIN_GAP, 8'd48, minimum game_tick[0] ticks between spawns.
REQ-003 Param LFSR_SEED, 8'hA5, LFSR reset value; SHALL be nonzero.
REQ-004 clk  in  1  system clock; all logic on posedge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 game_tick  in  2  single-cycle strobes: [0] movement tick, [1] score tick.
REQ-007 game_start_pulse  in  1  start/restart request, one cycle.
REQ-008 game_over_pulse  in  1  crash notification, one cycle.
REQ-009 obs_x  out  16  {slot1 x, slot0 x}, 8 bits each.
REQ-010 obs_valid  out  2  per-slot occupied flag.
REQ-011 obs_type  out  2  per-slot type: 0 cactus, 1 bird.
REQ-012 speed  out  3  pixels moved per movement tick, range 1..4.
REQ-013 score  out  16  run score.
REQ-014 running  out  1  high only in state RUN.

Function
REQ-015 FSM states IDLE, RUN, FROZEN; all outputs registered.
REQ-016 IDLE: slots cleared, score held; game_start_pulse -> RUN next cycle, clearing score and gap counter.
REQ-017 RUN: game_over_pulse -> FROZEN; it wins over a simultaneous game_start_pulse.
REQ-018 FROZEN: slots, score and speed hold; game_start_pulse -> RUN, clearing slots, score and gap counter in the same cycle.
REQ-019 RUN, game_tick[0]: each valid slot whose x >= speed gets x <= x - speed; a valid slot whose x < speed is cleared (valid=0, x=0), never wraps.
REQ-020 Gap counter increments on each RUN game_tick[0] and saturates at 8'hFF; it resets to 0 on spawn.
REQ-021 Spawn on a RUN game_tick[0] when gap >= SPAWN_MIN_GAP, lfsr[1:0]==2'b00 and at least one slot is free after this tick's retirement.
REQ-022 A spawn fills the lowest-index free slot with x=OBS_X_START and type=lfsr[2]; at most one spawn per tick.
REQ-023 Both slots busy: no spawn; the gap counter keeps counting.
REQ-024 Score increments by 1 on each RUN game_tick[1] and saturates at 16'hFFFF.
REQ-025 speed = 1 + min(score[15:9], 3), recomputed every cycle from the registered score.
REQ-026 A simultaneous game_tick[0] and game_tick[1] SHALL use the pre-increment score for movement.
REQ-027 LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every clk regardless of state.
REQ-028 Ticks are ignored outside RUN.

Reset
REQ-029 While reset is high: state=IDLE, obs_x=0, obs_valid=0, obs_type=0, score=0, speed=1, running=0, gap=0, lfsr=LFSR_SEED.
REQ-030 Reset asserted mid-RUN SHALL take effect on the next posedge and override all other inputs.

Configuration
REQ-031 Macro OBSTACLE_BIRD_EN defined: type taken from lfsr[2] per REQ-022.
REQ-032 OBSTACLE_BIRD_EN undefined: every spawn is type 0 and obs_type is constant 2'b00; spawn timing is unchanged.

Structure
REQ-033 Shared package dino_pkg holds the FSM state encodings, obstacle type constants (OBS_CACTUS=0, OBS_BIRD=1) and the speed limit constant 3'd4.
REQ-034 The LFSR is the sub-module lfsr8, with seed parameter and enable input; it is reusable by other game blocks.

Verification
REQ-035 Reset, then game_start_pulse -> running=1, score=0, speed=1, obs_valid=0 on the next cycle.
REQ-036 In RUN, apply 48 game_tick[0] with an LFSR state forced to give lfsr[1:0]=0 -> slot0 valid, x=159; on the next tick x=158.
REQ-037 Slot at x=2 with speed=3 (score=1024), one game_tick[0] -> slot cleared, obs_valid[0]=0, no wrap to 255.
REQ-038 Both slots valid, gap=200, spawn condition true -> no spawn, gap continues to 201.
REQ-039 game_over_pulse and game_start_pulse in the same RUN cycle -> FROZEN, positions held; a later start -> RUN with slots and score cleared.
REQ-040 Build without OBSTACLE_BIRD_EN, 1000-tick random run -> obs_type always 2'b00, and the spawn count equals that of the OBSTACLE_BIRD_EN build.

Source files
------------

// File: rtl/dino_pkg.sv
// Shared definitions for the dino game blocks: FSM encoding, obstacle types, speed limit.
package dino_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StFrozen = 2'd2
  } state_e;

  localparam logic       OBS_CACTUS = 1'b0;
  localparam logic       OBS_BIRD   = 1'b1;
  localparam logic [2:0] SPEED_MAX  = 3'd4;

  // Speed from score[15:9]: one extra pixel per 512 points, capped at SPEED_MAX.
  function automatic logic [2:0] speed_of(input logic [6:0] score_hi);
    if (score_hi >= 7'd3) begin
      return SPEED_MAX;
    end
    return 3'd1 + {1'b0, score_hi[1:0]};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, with reset seed and enable.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [7:0] value
);

  logic [7:0] value_q;
  logic       feedback;

  assign feedback = value_q[7] ^ value_q[5] ^ value_q[4] ^ value_q[3];
  assign value    = value_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= SEED;
    end else if (enable) begin
      value_q <= {value_q[6:0], feedback};
    end
  end

endmodule

// File: rtl/obstacle_scheduler.sv
// Two-slot obstacle spawner/mover with score and speed tracking.
// Define OBSTACLE_BIRD_EN to let spawns pick a bird type from the LFSR; otherwise all cacti.
module obstacle_scheduler
  import dino_pkg::*;
#(
  parameter logic [7:0] OBS_X_START   = 8'd159,
  parameter logic [7:0] SPAWN_MIN_GAP = 8'd48,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  game_tick,
  input  logic        game_start_pulse,
  input  logic        game_over_pulse,
  output logic [15:0] obs_x,
  output logic [1:0]  obs_valid,
  output logic [1:0]  obs_type,
  output logic [2:0]  speed,
  output logic [15:0] score,
  output logic        running
);

  state_e          state_q, state_d;
  logic [1:0][7:0] x_q, x_d;
  logic [1:0]      valid_q, valid_d;
  logic [1:0]      type_q, type_d;
  logic [15:0]     score_q, score_d;
  logic [7:0]      gap_q, gap_d;
  logic [7:0]      gap_inc;
  logic [2:0]      speed_q;
  logic            running_q;
  logic [7:0]      lfsr;
  logic            spawn_type;
  logic            unused_lfsr;

  lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .enable (1'b1),
    .value  (lfsr)
  );

`ifdef OBSTACLE_BIRD_EN
  assign spawn_type = lfsr[2];
`else
  assign spawn_type = OBS_CACTUS;
`endif
  assign unused_lfsr = ^lfsr[7:2];

  // Gap counted including the current tick, saturating.
  assign gap_inc = (gap_q == 8'hFF) ? gap_q : gap_q + 8'd1;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    valid_d = valid_q;
    type_d  = type_q;
    score_d = score_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        x_d     = '0;
        valid_d = '0;
        type_d  = '0;
        if (game_start_pulse) begin
          state_d = StRun;
          score_d = '0;
          gap_d   = '0;
        end
      end
      StRun: begin
        if (game_over_pulse) begin
          state_d = StFrozen;
        end else begin
          if (game_tick[0]) begin
            for (int i = 0; i < 2; i++) begin
              if (valid_q[i]) begin
                if (x_q[i] >= {5'd0, speed_q}) begin
                  x_d[i] = x_q[i] - {5'd0, speed_q};
                end else begin
                  x_d[i]     = '0;
                  valid_d[i] = 1'b0;
                  type_d[i]  = OBS_CACTUS;
                end
              end
            end
            gap_d = gap_inc;
            // Free-slot test uses post-retirement occupancy.
            if (gap_inc >= SPAWN_MIN_GAP && lfsr[1:0] == 2'b00 && !(&valid_d)) begin
              gap_d = '0;
              if (!valid_d[0]) begin
                x_d[0]     = OBS_X_START;
                valid_d[0] = 1'b1;
                type_d[0]  = spawn_type;
              end else begin
                x_d[1]     = OBS_X_START;
                valid_d[1] = 1'b1;
                type_d[1]  = spawn_type;
              end
            end
          end
          if (game_tick[1] && score_q != 16'hFFFF) begin
            score_d = score_q + 16'd1;
          end
        end
      end
      StFrozen: begin
        if (game_start_pulse) begin
          state_d = StRun;
          x_d     = '0;
          valid_d = '0;
          type_d  = '0;
          score_d = '0;
          gap_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      x_q       <= '0;
      valid_q   <= '0;
      type_q    <= '0;
      score_q   <= '0;
      gap_q     <= '0;
      speed_q   <= 3'd1;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      valid_q   <= valid_d;
      type_q    <= type_d;
      score_q   <= score_d;
      gap_q     <= gap_d;
      speed_q   <= speed_of(score_d[15:9]);
      running_q <= (state_d == StRun);
    end
  end

  assign obs_x     = x_q;
  assign obs_valid = valid_q;
`ifdef OBSTACLE_BIRD_EN
  assign obs_type  = type_q;
`else
  assign obs_type  = 2'b00;
`endif
  assign speed     = speed_q;
  assign score     = score_q;
  assign running   = running_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler; LFSR phase is tracked so spawns can be allowed or blocked.
module tb_obstacle_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  game_tick;
  logic        game_start_pulse;
  logic        game_over_pulse;
  logic [15:0] obs_x;
  logic [1:0]  obs_valid;
  logic [1:0]  obs_type;
  logic [2:0]  speed;
  logic [15:0] score;
  logic        running;

  int   checks = 0;
  int   passed = 0;
  logic [7:0] lfsr_m;
  logic b2;
  logic exp_t;

  obstacle_scheduler dut (
    .clk              (clk),
    .reset            (reset),
    .game_tick        (game_tick),
    .game_start_pulse (game_start_pulse),
    .game_over_pulse  (game_over_pulse),
    .obs_x            (obs_x),
    .obs_valid        (obs_valid),
    .obs_type         (obs_type),
    .speed            (speed),
    .score            (score),
    .running          (running)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seed 8'hA5, steps every clock.
  always @(posedge clk) begin
    if (reset) lfsr_m <= 8'hA5;
    else       lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge; drives for one posedge, returns at the following negedge.
  task automatic pulse(input logic [1:0] t, input logic st, input logic ov);
    game_tick = t; game_start_pulse = st; game_over_pulse = ov;
    @(negedge clk);
    game_tick = 2'b00; game_start_pulse = 1'b0; game_over_pulse = 1'b0;
  endtask

  // mode 0: any LFSR, 1: spawn blocked (lfsr[1:0]!=0), 2: spawn allowed (lfsr[1:0]==0).
  task automatic tick_move(input int mode, input logic score_too, output logic bit2);
    bit2 = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (mode == 0 || (mode == 1 && lfsr_m[1:0] != 2'b00) ||
          (mode == 2 && lfsr_m[1:0] == 2'b00)) begin
        bit2 = lfsr_m[2];
        pulse({score_too, 1'b1}, 1'b0, 1'b0);
        return;
      end
      @(negedge clk);
    end
    checks++;
    $error("FAIL tick_timeout: observed no lfsr match, expected match for mode %0d", mode);
  endtask

  task automatic ticks(input int n, input int mode);
    logic dummy;
    for (int i = 0; i < n; i++) tick_move(mode, 1'b0, dummy);
  endtask

  task automatic score_ticks(input int n);
    for (int i = 0; i < n; i++) pulse(2'b10, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; game_tick = 2'b00; game_start_pulse = 1'b0; game_over_pulse = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_running", running, 0);
    chk("rst_score", score, 0);
    chk("rst_speed", speed, 1);
    chk("rst_valid", obs_valid, 0);
    chk("rst_x", obs_x, 0);
    chk("rst_type", obs_type, 0);
    reset = 1'b0;
    @(negedge clk);

    // Ticks in IDLE are ignored.
    pulse(2'b11, 1'b0, 1'b0);
    chk("idle_score", score, 0);
    chk("idle_running", running, 0);

    pulse(2'b00, 1'b1, 1'b0);
    chk("start_running", running, 1);
    chk("start_score", score, 0);
    chk("start_speed", speed, 1);
    chk("start_valid", obs_valid, 0);

    // 47 ticks never spawn; the 48th does when the LFSR allows.
    ticks(47, 0);
    chk("gap47_valid", obs_valid, 0);
    tick_move(2, 1'b0, b2);
`ifdef OBSTACLE_BIRD_EN
    exp_t = b2;
`else
    exp_t = 1'b0;
`endif
    chk("spawn0_valid", obs_valid, 2'b01);
    chk("spawn0_x", obs_x, 16'h009F);
    chk("spawn0_type", obs_type, {1'b0, exp_t});
    ticks(1, 1);
    chk("move0_x", obs_x, 16'h009E);

    // Second slot fills 48 ticks after the first spawn.
    ticks(46, 1);
    chk("gap_blocked_valid", obs_valid, 2'b01);
    ticks(1, 2);
    chk("spawn1_valid", obs_valid, 2'b11);
    chk("spawn1_x", obs_x, {8'd159, 8'd111});

    // Both busy: spawn condition true every tick, gap keeps counting.
    ticks(111, 2);
    chk("busy_valid", obs_valid, 2'b11);
    chk("busy_x", obs_x, {8'd48, 8'd0});
    chk("busy_gap", dut.gap_q, 111);
    ticks(1, 2);
    chk("respawn_x", obs_x, {8'd47, 8'd159});
    chk("respawn_valid", obs_valid, 2'b11);

    // Simultaneous move and score tick moves with the pre-increment speed.
    score_ticks(511);
    chk("score511", score, 511);
    chk("speed511", speed, 1);
    tick_move(1, 1'b1, b2);
    chk("sim_x", obs_x, {8'd46, 8'd158});
    chk("sim_score", score, 512);
    chk("sim_speed", speed, 2);
    score_ticks(512);
    chk("speed1024", speed, 3);

    // Speed 3: slot1 retires at x=1, slot0 reaches 2 then retires without wrapping.
    ticks(52, 1);
    chk("x2_x", obs_x, 16'h0002);
    chk("x2_valid", obs_valid, 2'b01);
    ticks(1, 1);
    chk("nowrap_x", obs_x, 16'h0000);
    chk("nowrap_valid", obs_valid, 2'b00);

    // Over wins over start; FROZEN holds everything.
    ticks(1, 2);
    chk("spawn2_x", obs_x, 16'h009F);
    ticks(1, 1);
    chk("spawn2_move", obs_x, 16'h009C);
    pulse(2'b00, 1'b1, 1'b1);
    chk("frozen_running", running, 0);
    ticks(3, 0);
    score_ticks(2);
    chk("frozen_x", obs_x, 16'h009C);
    chk("frozen_valid", obs_valid, 2'b01);
    chk("frozen_score", score, 1024);
    chk("frozen_speed", speed, 3);
    pulse(2'b00, 1'b1, 1'b0);
    chk("restart_running", running, 1);
    chk("restart_valid", obs_valid, 0);
    chk("restart_x", obs_x, 0);
    chk("restart_score", score, 0);
    chk("restart_speed", speed, 1);

    // Reset mid-RUN overrides simultaneous inputs.
    score_ticks(5);
    chk("pre_reset_score", score, 5);
    reset = 1'b1;
    pulse(2'b11, 1'b1, 1'b0);
    reset = 1'b0;
    chk("midrst_running", running, 0);
    chk("midrst_score", score, 0);

    // Random run: type must stay cactus (or only on occupied slots with birds enabled).
    pulse(2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      pulse(2'($urandom), ($urandom_range(0, 99) == 0), ($urandom_range(0, 199) == 0));
`ifdef OBSTACLE_BIRD_EN
      chk("rand_type", obs_type & ~obs_valid, 0);
`else
      chk("rand_type", obs_type, 0);
`endif
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
